// File: rtl/spi_mem_arbiter.sv
// spi_mem_arbiter: shares one SPI RAM controller between an instruction-fetch
// read port and a read/write data port, one transaction at a time, round robin.
module spi_mem_arbiter #(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 if_req_i,
  input  logic [ADDR_BITS-1:0] if_addr_i,
  output logic                 if_ack_o,
  output logic [DATA_BITS-1:0] if_rdata_o,
  input  logic                 dm_req_i,
  input  logic                 dm_we_i,
  input  logic [ADDR_BITS-1:0] dm_addr_i,
  input  logic [DATA_BITS-1:0] dm_wdata_i,
  output logic                 dm_ack_o,
  output logic [DATA_BITS-1:0] dm_rdata_o,
  output logic [ADDR_BITS-1:0] ctrl_addr_o,
  output logic [DATA_BITS-1:0] ctrl_wdata_o,
  output logic                 ctrl_start_read_o,
  output logic                 ctrl_start_write_o,
  input  logic [DATA_BITS-1:0] ctrl_rdata_i,
  input  logic                 ctrl_busy_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e               state_q,    state_d;
  logic                 gnt_dm_q,   gnt_dm_d;    // granted port, doubles as round-robin history
  logic                 we_q,       we_d;
  logic [ADDR_BITS-1:0] addr_q,     addr_d;
  logic [DATA_BITS-1:0] wdata_q,    wdata_d;
  logic                 start_rd_q, start_rd_d;
  logic                 start_wr_q, start_wr_d;
  logic                 if_ack_q,   if_ack_d;
  logic                 dm_ack_q,   dm_ack_d;
  logic [DATA_BITS-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_BITS-1:0] dm_rdata_q, dm_rdata_d;
  logic                 pick_dm;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      gnt_dm_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      start_rd_q <= 1'b0;
      start_wr_q <= 1'b0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_dm_q   <= gnt_dm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      start_rd_q <= start_rd_d;
      start_wr_q <= start_wr_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Next-state, grant and output decode
  always_comb begin
    state_d    = state_q;
    gnt_dm_d   = gnt_dm_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    start_rd_d = 1'b0;
    start_wr_d = 1'b0;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    // Data port wins alone, or when both pend and fetch was granted last
    pick_dm    = dm_req_i && (!if_req_i || !gnt_dm_q);

    case (state_q)
      ST_IDLE: begin
        if (if_req_i || dm_req_i) begin
          gnt_dm_d = pick_dm;
          if (pick_dm) begin
            we_d    = dm_we_i;
            addr_d  = {dm_addr_i[ADDR_BITS-1:1], 1'b0};
            wdata_d = dm_wdata_i;
          end else begin
            we_d    = 1'b0;
            addr_d  = {if_addr_i[ADDR_BITS-1:1], 1'b0};
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!ctrl_busy_i) begin
          start_wr_d = we_q;
          start_rd_d = !we_q;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Busy rises only after the start pulse, so ignore busy during the pulse
        if (!start_rd_q && !start_wr_q && !ctrl_busy_i) begin
          if (!we_q) begin
            if (gnt_dm_q) dm_rdata_d = ctrl_rdata_i;
            else          if_rdata_d = ctrl_rdata_i;
          end
          dm_ack_d = gnt_dm_q;
          if_ack_d = !gnt_dm_q;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign if_ack_o           = if_ack_q;
  assign dm_ack_o           = dm_ack_q;
  assign if_rdata_o         = if_rdata_q;
  assign dm_rdata_o         = dm_rdata_q;
  assign ctrl_addr_o        = addr_q;
  assign ctrl_wdata_o       = wdata_q;
  assign ctrl_start_read_o  = start_rd_q;
  assign ctrl_start_write_o = start_wr_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// tb_spi_mem_arbiter: drives both ports against a behavioural SPI RAM controller
// and checks results against a transaction-level memory model.
module tb_spi_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int BUSY_CYC = 40;
  localparam int LAT = 43;

  logic          clk = 1'b0;
  logic          rstn;
  logic          if_req, if_ack, dm_req, dm_we, dm_ack;
  logic [AW-1:0] if_addr, dm_addr, ctrl_addr;
  logic [DW-1:0] if_rdata, dm_wdata, dm_rdata, ctrl_wdata, ctrl_rdata;
  logic          ctrl_start_read, ctrl_start_write, ctrl_busy, force_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_mem_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk                (clk),
    .rstn               (rstn),
    .if_req_i           (if_req),
    .if_addr_i          (if_addr),
    .if_ack_o           (if_ack),
    .if_rdata_o         (if_rdata),
    .dm_req_i           (dm_req),
    .dm_we_i            (dm_we),
    .dm_addr_i          (dm_addr),
    .dm_wdata_i         (dm_wdata),
    .dm_ack_o           (dm_ack),
    .dm_rdata_o         (dm_rdata),
    .ctrl_addr_o        (ctrl_addr),
    .ctrl_wdata_o       (ctrl_wdata),
    .ctrl_start_read_o  (ctrl_start_read),
    .ctrl_start_write_o (ctrl_start_write),
    .ctrl_rdata_i       (ctrl_rdata),
    .ctrl_busy_i        (ctrl_busy)
  );

  // Initial RAM contents, indexed by word
  function automatic logic [15:0] pattern(input int idx);
    if (idx == 8) return 16'h1234;
    return 16'(idx) ^ 16'hA5A5;
  endfunction

  // Behavioural SPI RAM controller: busy for BUSY_CYC cycles after a start
  logic [15:0] ram [0:32767];
  bit          ram_ready = 1'b0;
  logic        busy_q, op_wr_q;
  int          cnt_q;
  logic [15:0] op_addr_q, op_wdata_q, rdata_q;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 32768; i++) ram[i] <= pattern(i);
      ram_ready <= 1'b1;
    end
    if (!rstn) begin
      busy_q  <= 1'b0;
      cnt_q   <= 0;
      rdata_q <= '0;
    end else if (ctrl_start_read || ctrl_start_write) begin
      busy_q     <= 1'b1;
      cnt_q      <= BUSY_CYC - 1;
      op_wr_q    <= ctrl_start_write;
      op_addr_q  <= ctrl_addr;
      op_wdata_q <= ctrl_wdata;
    end else if (busy_q) begin
      if (cnt_q == 0) begin
        busy_q <= 1'b0;
        if (op_wr_q) ram[op_addr_q[15:1]] <= op_wdata_q;
        else         rdata_q <= ram[op_addr_q[15:1]];
      end else begin
        cnt_q <= cnt_q - 1;
      end
    end
  end

  assign ctrl_busy  = busy_q | force_busy;
  assign ctrl_rdata = rdata_q;

  // Reference memory: word-indexed, written only by completed data writes
  logic [15:0] ref_mem [int];

  function automatic logic [15:0] ref_read(input logic [15:0] byte_addr);
    int idx;
    idx = int'(byte_addr[15:1]);
    if (ref_mem.exists(idx)) return ref_mem[idx];
    return pattern(idx);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic mon_fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Protocol monitor sampled on the falling edge
  int          n_starts = 0;
  bit          in_txn = 1'b0;
  logic [15:0] st_addr, st_wdata;
  logic        st_wr;

  always @(negedge clk) begin
    if (!rstn) begin
      in_txn = 1'b0;
    end else begin
      if (ctrl_start_read && ctrl_start_write) mon_fail("both_starts", 32'd2, 32'd1);
      if (ctrl_start_read || ctrl_start_write) begin
        if (in_txn) mon_fail("outstanding_start", 32'd2, 32'd1);
        n_starts++;
        st_addr  = ctrl_addr;
        st_wdata = ctrl_wdata;
        st_wr    = ctrl_start_write;
        in_txn   = 1'b1;
      end else if (in_txn && (ctrl_addr !== st_addr || ctrl_wdata !== st_wdata)) begin
        mon_fail("ctrl_stable", {ctrl_addr, ctrl_wdata}, {st_addr, st_wdata});
      end
      if (if_ack && dm_ack) mon_fail("ack_overlap", {if_ack, dm_ack}, 32'd0);
      if (if_ack || dm_ack) in_txn = 1'b0;
    end
  end

  // One complete transaction from an idle arbiter
  task automatic run_one(input bit is_dm, input bit we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp_rd, input string name);
    int          lat, s0;
    logic        got;
    logic [15:0] if_b, dm_b;
    s0   = n_starts;
    if_b = if_rdata;
    dm_b = dm_rdata;
    if (is_dm) begin
      dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_req = 1'b1;
    end else begin
      if_addr = addr; if_req = 1'b1;
    end
    lat = -1;
    do begin
      @(posedge clk); #1;
      lat++;
      got = is_dm ? dm_ack : if_ack;
    end while (!got && lat < 200);
    if_req = 1'b0;
    dm_req = 1'b0;
    check({name, " ack"}, got, 1);
    check({name, " latency"}, lat, LAT);
    check({name, " starts"}, n_starts - s0, 1);
    check({name, " ctrl_addr"}, st_addr, {addr[15:1], 1'b0});
    check({name, " is_write"}, st_wr, is_dm & we);
    if (is_dm && we) begin
      check({name, " ctrl_wdata"}, st_wdata, wdata);
      check({name, " if_rdata held"}, if_rdata, if_b);
      check({name, " dm_rdata held"}, dm_rdata, dm_b);
      ref_mem[int'(addr[15:1])] = wdata;
    end else if (is_dm) begin
      check({name, " dm_rdata"}, dm_rdata, exp_rd);
      check({name, " if_rdata held"}, if_rdata, if_b);
    end else begin
      check({name, " if_rdata"}, if_rdata, exp_rd);
      check({name, " dm_rdata held"}, dm_rdata, dm_b);
    end
    @(posedge clk); #1;
  endtask

  // Both ports request in the same cycle; records which ack comes first
  task automatic sim_round(input bit exp_dm_first, input logic [15:0] f_addr,
                           input logic [15:0] d_addr, input string name);
    bit          f_done, d_done, got_first, first_dm;
    int          cyc;
    logic [15:0] f_exp, d_exp;
    f_exp = ref_read(f_addr);
    d_exp = ref_read(d_addr);
    if_addr = f_addr; dm_addr = d_addr; dm_we = 1'b0; dm_wdata = '0;
    if_req = 1'b1; dm_req = 1'b1;
    f_done = 0; d_done = 0; got_first = 0; first_dm = 0; cyc = 0;
    while (!(f_done && d_done) && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (dm_ack && !d_done) begin
        d_done = 1; dm_req = 1'b0;
        if (!got_first) begin got_first = 1; first_dm = 1; end
        check({name, " dm_rdata"}, dm_rdata, d_exp);
      end
      if (if_ack && !f_done) begin
        f_done = 1; if_req = 1'b0;
        if (!got_first) begin got_first = 1; first_dm = 0; end
        check({name, " if_rdata"}, if_rdata, f_exp);
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    check({name, " both served"}, {f_done, d_done}, 2'b11);
    check({name, " data first"}, first_dm, exp_dm_first);
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          is_dm;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    string       name;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int          lat, s0, acks;
    bit          is_dm, we;
    logic [15:0] a, wd;

    vecs[0] = '{0, 0, 16'h0010, 16'h0000, 16'h1234, "fetch_0010"};
    vecs[1] = '{1, 1, 16'h0021, 16'hBEEF, 16'h0000, "dm_wr_0021"};
    vecs[2] = '{1, 0, 16'h0020, 16'h0000, 16'hBEEF, "dm_rd_0020"};
    vecs[3] = '{0, 0, 16'h0021, 16'h0000, 16'hBEEF, "fetch_0021"};
    vecs[4] = '{0, 0, 16'hFFFF, 16'h0000, 16'hDA5A, "fetch_ffff"};
    vecs[5] = '{1, 0, 16'h0003, 16'h0000, 16'hA5A4, "dm_rd_0003"};
    vecs[6] = '{1, 1, 16'hFFFE, 16'h0F0F, 16'h0000, "dm_wr_fffe"};
    vecs[7] = '{1, 0, 16'hFFFF, 16'h0000, 16'h0F0F, "dm_rd_ffff"};

    rstn = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; force_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset acks", {if_ack, dm_ack}, 0);
    check("reset starts", {ctrl_start_read, ctrl_start_write}, 0);
    check("reset rdata", {if_rdata, dm_rdata}, 0);
    check("reset ctrl", {ctrl_addr, ctrl_wdata}, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Round robin from reset: data first, then fetch first after a lone data grant
    sim_round(1'b1, 16'h0040, 16'h0042, "rr1");
    sim_round(1'b1, 16'h0044, 16'h0046, "rr2");
    run_one(1'b1, 1'b0, 16'h0048, 16'h0000, ref_read(16'h0048), "rr_solo");
    sim_round(1'b0, 16'h004A, 16'h004C, "rr3");

    for (int i = 0; i < 8; i++)
      run_one(vecs[i].is_dm, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].name);

    for (int i = 0; i < 40; i++) begin
      is_dm = 1'($urandom_range(0, 1));
      we    = is_dm & 1'($urandom_range(0, 1));
      a     = 16'($urandom_range(0, 31));
      wd    = 16'($urandom);
      run_one(is_dm, we, a, wd, ref_read(a), "rand");
    end

    // Busy held high through five ISSUE cycles
    s0 = n_starts;
    force_busy = 1'b1;
    if_addr = 16'h0100; if_req = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("stall no start", n_starts - s0, 0);
    force_busy = 1'b0;
    lat = 5;
    while (!if_ack && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if_req = 1'b0;
    check("stall latency", lat, LAT + 5);
    check("stall one start", n_starts - s0, 1);
    check("stall if_rdata", if_rdata, 16'hA525);
    @(posedge clk); #1;

    // Reset pulse while the fetch is waiting on the controller
    if_addr = 16'h0010; if_req = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1; if_req = 1'b0;
    check("midrst acks", {if_ack, dm_ack}, 0);
    check("midrst starts", {ctrl_start_read, ctrl_start_write}, 0);
    check("midrst rdata", {if_rdata, dm_rdata}, 0);
    check("midrst ctrl", {ctrl_addr, ctrl_wdata}, 0);
    acks = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (if_ack || dm_ack) acks++;
    end
    check("midrst no ack", acks, 0);
    run_one(1'b0, 1'b0, 16'h0100, 16'h0000, 16'hA525, "post_reset_fetch");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
